// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: drives one word-wide bus transaction per
// load/store and returns the extended load result.
//
// Build option: define MEM_MISALIGN_CHECK_EN to flag misaligned LW/SW and
// LH/LHU/SH as address errors (adel/ades) instead of issuing them.
//
// Ports
//   clk, reset                 clock, async active-low reset
//   valid_in, mem_op           EX/MEM slot live flag and memory opcode
//   addr, wdata                effective address and store data
//   bus_rdata, bus_ack         memory read word and completion strobe
//   bus_req, bus_we            request strobe and write flag
//   bus_addr, bus_wdata        word-aligned address and lane-placed data
//   bus_be                     byte enables (bit i = byte lane i)
//   load_data                  extended load result, valid while done=1
//   done, bus_err              completion pulse and timeout pulse
//   stall                      freeze IF/ID/EX and the EX/MEM register
//   adel, ades                 load/store address-error flags
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic [31:0] load_data,
    output logic        done,
    output logic        bus_err,
    output logic        stall,
    output logic        adel,
    output logic        ades
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [3:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] load_q;
    logic        err_q;

    logic        is_load, is_store, active, misaligned, start, timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // Select and extend the addressed byte/halfword of the returned word.
    // Stores return zero so load_data never shows stale bus data.
    function automatic logic [31:0] extract(input logic [3:0] op,
                                            input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LW:   extract = w;
            OP_LH:   extract = {{16{h[15]}}, h};
            OP_LHU:  extract = {16'h0000, h};
            OP_LB:   extract = {{24{b[7]}}, b};
            OP_LBU:  extract = {24'h000000, b};
            default: extract = 32'h0;
        endcase
    endfunction

    always_comb begin
        is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
        is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);
        active   = valid_in && (is_load || is_store);
`ifdef MEM_MISALIGN_CHECK_EN
        misaligned = (((mem_op == OP_LW) || (mem_op == OP_SW)) && (addr[1:0] != 2'b00)) ||
                     (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && addr[0]);
`else
        misaligned = 1'b0;
`endif
    end

    // Lane placement; misaligned words (check disabled) simply use lane 0.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        case (mem_op)
            OP_SH: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            OP_SB: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign start   = (state_q == S_IDLE) && active && !misaligned;
    assign timeout = (state_q == S_WAIT) && !bus_ack && (wait_cnt == TO_LAST);

    assign stall     = active && (state_q != S_DONE) && !misaligned;
    assign adel      = reset && active && is_load  && misaligned;
    assign ades      = reset && active && is_store && misaligned;
    assign done      = (state_q == S_DONE);
    assign bus_err   = err_q;
    assign load_data = load_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_WAIT;
            // ack wins over a coincident timeout
            S_WAIT: if (bus_ack || timeout) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 8'h00;
            op_q      <= 4'h0;
            lo_q      <= 2'b00;
            load_q    <= 32'h0;
            err_q     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'h0;
        end else begin
            // bus_err is high exactly for the DONE cycle after a timeout
            err_q <= timeout;
            if (start) begin
                wait_cnt  <= 8'h00;
                op_q      <= mem_op;
                lo_q      <= addr[1:0];
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= wdata_d;
                bus_be    <= be_d;
            end else if (state_q == S_WAIT) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    load_q  <= extract(op_q, lo_q, bus_rdata);
                end else if (timeout) begin
                    bus_req <= 1'b0;
                    load_q  <= 32'h0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYCLES=4): a vector table of
// complete transactions plus hand sequences for reset, timeout and
// misalignment corners.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata, bus_rdata;
    logic        bus_ack;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] load_data;
    logic        done, bus_err, stall, adel, ades;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .load_data(load_data),
        .done(done), .bus_err(bus_err), .stall(stall), .adel(adel), .ades(ades)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;     // WAIT cycles before ack
        logic [3:0]  be;
        logic [31:0] bwd;
        logic        we;
        logic [31:0] ld;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; entered and left one step after an edge in IDLE.
    task automatic run_vec(input vec_t v);
        valid_in = 1'b1; mem_op = v.op; addr = v.addr; wdata = v.wdata; bus_ack = 1'b0;
        #1;
        chk("idle_stall", stall, 1);
        chk("idle_adel", adel, 0);
        chk("idle_ades", ades, 0);
        tick();
        chk("req", bus_req, 1);
        chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("bus_be", bus_be, v.be);
        chk("bus_wdata", bus_wdata, v.bwd);
        chk("bus_we", bus_we, v.we);
        chk("wait_stall", stall, 1);
        for (int i = 0; i < v.dly; i++) begin
            tick();
            chk("wait_req", bus_req, 1);
            chk("wait_done", done, 0);
        end
        bus_rdata = v.rdata; bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("done", done, 1);
        chk("done_err", bus_err, 0);
        chk("load_data", load_data, v.ld);
        chk("done_req", bus_req, 0);
        chk("done_stall", stall, 0);
        tick();
        chk("idle_done", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //        op    addr          wdata         rdata         dly be       bwd           we    ld
        vt[0]  = '{4'd1, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF};
        vt[1]  = '{4'd8, 32'h0000_2003, 32'h0000_00A5, 32'h0,        1, 4'b1000, 32'hA5A5_A5A5, 1'b1, 32'h0};
        vt[2]  = '{4'd4, 32'h0000_2003, 32'h0,        32'h8000_0000, 0, 4'b1111, 32'h0,        1'b0, 32'hFFFF_FF80};
        vt[3]  = '{4'd5, 32'h0000_2003, 32'h0,        32'h8000_0000, 0, 4'b1111, 32'h0,        1'b0, 32'h0000_0080};
        vt[4]  = '{4'd2, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 2, 4'b1111, 32'h0,        1'b0, 32'hFFFF_8001};
        vt[5]  = '{4'd3, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 0, 4'b1111, 32'h0,        1'b0, 32'h0000_8001};
        vt[6]  = '{4'd2, 32'h0000_2000, 32'h0,        32'h8001_7FFF, 1, 4'b1111, 32'h0,        1'b0, 32'h0000_7FFF};
        vt[7]  = '{4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0};
        vt[8]  = '{4'd7, 32'h0000_2000, 32'h1234_ABCD, 32'h0,        0, 4'b0011, 32'hABCD_ABCD, 1'b1, 32'h0};
        vt[9]  = '{4'd6, 32'h0000_3008, 32'hCAFE_F00D, 32'h0,        2, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0};
        vt[10] = '{4'd8, 32'h0000_2001, 32'h0000_005A, 32'h0,        0, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0};
        vt[11] = '{4'd4, 32'h0000_2001, 32'h0,        32'h0000_7F00, 0, 4'b1111, 32'h0,        1'b0, 32'h0000_007F};
        // ack in the 4th (last) WAIT cycle: completion beats timeout
        vt[12] = '{4'd1, 32'h0000_1008, 32'h0,        32'h1122_3344, 3, 4'b1111, 32'h0,        1'b0, 32'h1122_3344};

        reset = 1'b0; valid_in = 1'b0; mem_op = 4'd0; addr = 32'h0; wdata = 32'h0;
        bus_rdata = 32'h0; bus_ack = 1'b0;
        #2;
        chk("rst_req", bus_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_load", load_data, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // Timeout: no ack, 4 WAIT cycles then DONE with bus_err.
        valid_in = 1'b1; mem_op = 4'd1; addr = 32'h0000_1000; bus_ack = 1'b0;
        tick();
        chk("to_req", bus_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_done", done, 0);
            chk("to_wait_err", bus_err, 0);
            chk("to_wait_req", bus_req, 1);
        end
        tick();
        chk("to_done", done, 1);
        chk("to_err", bus_err, 1);
        chk("to_load", load_data, 0);
        chk("to_req_off", bus_req, 0);
        bus_ack = 1'b1; valid_in = 1'b0;
        tick();
        chk("to_idle_done", done, 0);
        chk("to_idle_err", bus_err, 0);
        tick();
        chk("ack_idle_done", done, 0);
        chk("ack_idle_req", bus_req, 0);
        bus_ack = 1'b0;

        // Inactive slots never stall or request.
        valid_in = 1'b1; mem_op = 4'd9; addr = 32'h0000_1000;
        #1 chk("bad_op_stall", stall, 0);
        tick();
        chk("bad_op_req", bus_req, 0);
        valid_in = 1'b0; mem_op = 4'd1;
        #1 chk("novalid_stall", stall, 0);
        tick();
        chk("novalid_req", bus_req, 0);

        // Reset in the 2nd WAIT cycle of an LH.
        valid_in = 1'b1; mem_op = 4'd2; addr = 32'h0000_2002;
        tick();
        chk("rw_req1", bus_req, 1);
        tick();
        chk("rw_req2", bus_req, 1);
        #2 reset = 1'b0;
        #1 chk("rw_req_drop", bus_req, 0);
        chk("rw_done", done, 0);
        valid_in = 1'b0;
        tick();
        chk("rw_done2", done, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rw_stall", stall, 0);
        tick();
        chk("rw_post_done", done, 0);
        chk("rw_post_req", bus_req, 0);

        // Misaligned LH 0x3001 and SW 0x3002.
        valid_in = 1'b1; mem_op = 4'd2; addr = 32'h0000_3001; wdata = 32'h0;
`ifdef MEM_MISALIGN_CHECK_EN
        #1;
        chk("mis_lh_adel", adel, 1);
        chk("mis_lh_stall", stall, 0);
        tick();
        chk("mis_lh_req", bus_req, 0);
        mem_op = 4'd6; addr = 32'h0000_3002;
        #1;
        chk("mis_sw_ades", ades, 1);
        chk("mis_sw_adel", adel, 0);
        chk("mis_sw_stall", stall, 0);
        tick();
        chk("mis_sw_req", bus_req, 0);
        valid_in = 1'b0;
`else
        #1;
        chk("mis_lh_adel", adel, 0);
        chk("mis_lh_stall", stall, 1);
        tick();
        chk("mis_lh_req", bus_req, 1);
        chk("mis_lh_addr", bus_addr, 32'h0000_3000);
        bus_rdata = 32'h0000_BEEF; bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("mis_lh_done", done, 1);
        chk("mis_lh_load", load_data, 32'hFFFF_BEEF);
        tick();
        mem_op = 4'd6; addr = 32'h0000_3002; wdata = 32'h1234_5678;
        #1 chk("mis_sw_ades", ades, 0);
        tick();
        chk("mis_sw_req", bus_req, 1);
        chk("mis_sw_be", bus_be, 4'b1111);
        chk("mis_sw_addr", bus_addr, 32'h0000_3000);
        chk("mis_sw_wdata", bus_wdata, 32'h1234_5678);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("mis_sw_done", done, 1);
        valid_in = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before a bus error; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  EX/MEM slot holds a live instruction.
REQ-005 mem_op  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; all other codes mean NONE.
REQ-006 addr  input  32  effective address, the EX ALU result.
REQ-007 wdata  input  32  store data, the forwarded rt value from EX.
REQ-008 bus_rdata  input  32  word returned by memory.
REQ-009 bus_ack  input  1  memory completes the request in this cycle.
REQ-010 bus_req, bus_we  output  1 each  request strobe and write flag.
REQ-011 bus_addr, bus_wdata  output  32 each  word-aligned address ({addr[31:2],2'b00}) and lane-placed data.
REQ-012 bus_be  output  4  byte enables; bit i selects byte lane i.
REQ-013 load_data  output  32  extended load result, valid while done=1.
REQ-014 done, bus_err  output  1 each  one-cycle completion pulse and one-cycle timeout pulse.
REQ-015 stall  output  1  freeze IF/ID/EX and the EX/MEM register.
REQ-016 adel, ades  output  1 each  load and store address-error flags.

Function
REQ-017 The block SHALL treat an access as active when valid_in=1 and mem_op is 1..8.
REQ-018 FSM states SHALL be IDLE, WAIT and DONE.
REQ-019 IDLE -> WAIT SHALL occur on the next edge after an active, aligned access, registering bus_addr, bus_wdata, bus_be and bus_we and setting bus_req=1.
REQ-020 In WAIT, bus_req and all bus_* outputs SHALL stay stable until the cycle after bus_ack=1.
REQ-021 WAIT -> DONE SHALL occur on the edge where bus_ack=1; bus_rdata SHALL be captured on that edge and bus_req cleared.
REQ-022 DONE SHALL last exactly one cycle with done=1, and then SHALL return to IDLE.
REQ-023 stall SHALL equal active AND (state != DONE) AND NOT misaligned, computed combinationally.
REQ-024 Minimum latency SHALL be 3 cycles: IDLE, WAIT with ack, then DONE.
REQ-025 A WAIT cycle counter SHALL be cleared on entering WAIT; when it reaches TIMEOUT_CYCLES without bus_ack, the FSM SHALL go to DONE with bus_err=1 for that cycle and load_data=0.
REQ-026 bus_ack arriving in the same cycle as the timeout SHALL take priority: normal completion, bus_err=0.
REQ-027 bus_ack SHALL be ignored in IDLE and in DONE.
REQ-028 Byte enables:
- SW: bus_be=1111.
- SH: bus_be=0011 if addr[1]=0, else 1100.
- SB: bus_be=0001<<addr[1:0].
- Loads: bus_be=1111 with bus_we=0.
REQ-029 Store data placement: SH SHALL replicate wdata[15:0] to both halves; SB SHALL replicate wdata[7:0] to all four bytes.
REQ-030 Load extraction: the byte or halfword SHALL be selected by the registered addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the full word.
REQ-031 After done, the pipeline advances; a new active access seen in IDLE SHALL start a new transaction with no required bubble.

Reset
REQ-032 On reset=0 the FSM SHALL enter IDLE immediately (asynchronously) and clear the counter, all bus_* outputs, load_data, done, bus_err, adel and ades.
REQ-033 Reset during WAIT SHALL abandon the transaction: bus_req drops asynchronously and no done pulse is produced.

Configuration
REQ-034 With MEM_MISALIGN_CHECK_EN defined, the block SHALL assert adel/ades combinationally, with no bus request and stall=0, for these accesses:
- LW/SW with addr[1:0]!=0.
- LH/LHU/SH with addr[0]=1.
REQ-035 Without MEM_MISALIGN_CHECK_EN, adel and ades SHALL be tied to 0, and misaligned accesses SHALL proceed using the lane placement above; SW/LW use lane 0.

Verification
REQ-036 LW addr=0x1004 with memory word 0xDEADBEEF, ack in the first WAIT cycle -> bus_addr=0x1004, be=1111, done in cycle 3, load_data=0xDEADBEEF, stall high for 2 cycles.
REQ-037 SB addr=0x2003, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; LB from the same address with word 0x80000000 -> load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-038 TIMEOUT_CYCLES=4 with bus_ack never asserted -> bus_err and done pulse together after 4 WAIT cycles, load_data=0, then state IDLE.
REQ-039 Reset pulled low in the 2nd WAIT cycle of an LH -> bus_req=0 within the same cycle, no done pulse; after reset release, stall=0 with valid_in=0.
REQ-040 With MEM_MISALIGN_CHECK_EN: LH addr=0x3001 -> adel=1, bus_req=0, stall=0; SW addr=0x3002 -> ades=1. Without the macro, the same LH -> bus_req=1, adel=0.
